// File: rtl/irq_pending_if.sv
// Request/grant bundle between the pending unit and its driver/controller side.
`timescale 1ns/1ps
interface irq_pending_if #(
  parameter int unsigned NUM_TASKS = 4
);
  logic [NUM_TASKS-1:0] irq_raw;
  logic [NUM_TASKS-1:0] edge_mode;
  logic [NUM_TASKS-1:0] mask;
  logic [NUM_TASKS-1:0] grant;
  logic [NUM_TASKS-1:0] done;
  logic                 overflow_clr;
  logic [NUM_TASKS-1:0] pending;
  logic [NUM_TASKS-1:0] active;
  logic [NUM_TASKS-1:0] overflow;
  logic                 irq_any;

  modport master (
    output irq_raw, edge_mode, mask, grant, done, overflow_clr,
    input  pending, active, overflow, irq_any
  );

  modport slave (
    input  irq_raw, edge_mode, mask, grant, done, overflow_clr,
    output pending, active, overflow, irq_any
  );
endinterface

// File: rtl/irq_pending_unit.sv
// Request front-end for priority_controller: sync, event detect, per-channel IDLE/PEND/ACT hold.
// Optional macro IRQ_REQUEUE_EN adds a 1-deep requeue slot per channel.
`timescale 1ns/1ps
module irq_pending_unit #(
  parameter int unsigned NUM_TASKS   = 4,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  irq_pending_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PEND = 2'd1,
    ST_ACT  = 2'd2
  } state_e;

  logic [NUM_TASKS-1:0] sync_q [SYNC_STAGES];
  logic [NUM_TASKS-1:0] prev_q;
  logic [NUM_TASKS-1:0] sync_s;
  logic [NUM_TASKS-1:0] ev;

  state_e               state_q [NUM_TASKS];
  state_e               state_d [NUM_TASKS];
  logic [NUM_TASKS-1:0] ovf_set;
  logic [NUM_TASKS-1:0] pending_q, pending_d;
  logic [NUM_TASKS-1:0] active_q, active_d;
  logic [NUM_TASKS-1:0] overflow_q, overflow_d;
  logic                 irq_any_q, irq_any_d;
`ifdef IRQ_REQUEUE_EN
  logic [NUM_TASKS-1:0] rq_q, rq_d;
`endif

  // Synchroniser chain plus one delayed sample for rising-edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < int'(SYNC_STAGES); k++) sync_q[k] <= '0;
      prev_q <= '0;
    end else begin
      sync_q[0] <= bus.irq_raw;
      for (int k = 1; k < int'(SYNC_STAGES); k++) sync_q[k] <= sync_q[k-1];
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign sync_s = sync_q[SYNC_STAGES-1];
  assign ev     = sync_s & ~bus.mask & (~prev_q | ~bus.edge_mode);

  // Per-channel state registers and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(NUM_TASKS); i++) state_q[i] <= ST_IDLE;
      pending_q  <= '0;
      active_q   <= '0;
      overflow_q <= '0;
      irq_any_q  <= 1'b0;
`ifdef IRQ_REQUEUE_EN
      rq_q       <= '0;
`endif
    end else begin
      for (int i = 0; i < int'(NUM_TASKS); i++) state_q[i] <= state_d[i];
      pending_q  <= pending_d;
      active_q   <= active_d;
      overflow_q <= overflow_d;
      irq_any_q  <= irq_any_d;
`ifdef IRQ_REQUEUE_EN
      rq_q       <= rq_d;
`endif
    end
  end

  // Next-state, overflow and output decode; only edge-mode events count as lost
  always_comb begin
    ovf_set   = '0;
    pending_d = '0;
    active_d  = '0;
`ifdef IRQ_REQUEUE_EN
    rq_d      = rq_q;
`endif
    for (int i = 0; i < int'(NUM_TASKS); i++) begin
      state_d[i] = state_q[i];
      case (state_q[i])
        ST_IDLE: begin
          if (ev[i]) state_d[i] = ST_PEND;
        end
        ST_PEND: begin
          if (bus.grant[i] && !bus.mask[i]) state_d[i] = ST_ACT;
          if (ev[i] && bus.edge_mode[i]) ovf_set[i] = 1'b1;
        end
        ST_ACT: begin
          if (bus.done[i]) begin
`ifdef IRQ_REQUEUE_EN
            // A masked channel completing drops its queued request
            state_d[i] = (ev[i] || (rq_q[i] && !bus.mask[i])) ? ST_PEND : ST_IDLE;
            rq_d[i]    = 1'b0;
`else
            state_d[i] = ev[i] ? ST_PEND : ST_IDLE;
`endif
          end else if (ev[i] && bus.edge_mode[i]) begin
`ifdef IRQ_REQUEUE_EN
            if (!rq_q[i]) rq_d[i] = 1'b1;
            else          ovf_set[i] = 1'b1;
`else
            ovf_set[i] = 1'b1;
`endif
          end
        end
        default: state_d[i] = ST_IDLE;
      endcase
      pending_d[i] = ((state_d[i] == ST_PEND) && !bus.mask[i]) || (state_d[i] == ST_ACT);
      active_d[i]  = (state_d[i] == ST_ACT);
    end
    overflow_d = ovf_set | (overflow_q & ~{NUM_TASKS{bus.overflow_clr}});
    irq_any_d  = |pending_d;
  end

  assign bus.pending  = pending_q;
  assign bus.active   = active_q;
  assign bus.overflow = overflow_q;
  assign bus.irq_any  = irq_any_q;

endmodule

// File: tb/tb_irq_pending_unit.sv
// Directed self-checking bench for irq_pending_unit (default and IRQ_REQUEUE_EN builds).
`timescale 1ns/1ps
module tb_irq_pending_unit;

  localparam int unsigned NT = 4;
`ifdef IRQ_REQUEUE_EN
  localparam bit REQ_EN = 1'b1;
`else
  localparam bit REQ_EN = 1'b0;
`endif

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  irq_pending_if #(.NUM_TASKS(NT)) bus ();

  irq_pending_unit #(.NUM_TASKS(NT), .SYNC_STAGES(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Leaves a fresh synchronised rising edge on channel ch, applied at the next edge
  task automatic raise_to_ev(input int ch);
    bus.irq_raw[ch] = 1'b0;
    tick(3);
    bus.irq_raw[ch] = 1'b1;
    tick(2);
  endtask

  task automatic grant_one(input logic [NT-1:0] g);
    bus.grant = g;
    tick();
    bus.grant = '0;
  endtask

  task automatic done_one(input logic [NT-1:0] d);
    bus.done = d;
    tick();
    bus.done = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: got=running exp=finished");
    $fatal(1, "timeout");
  end

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    bus.irq_raw      = '0;
    bus.edge_mode    = 4'b1011;
    bus.mask         = '0;
    bus.grant        = '0;
    bus.done         = '0;
    bus.overflow_clr = 1'b0;

    // Reset state
    #3;
    check("rst_pending", 32'(bus.pending), 32'h0);
    check("rst_active", 32'(bus.active), 32'h0);
    check("rst_overflow", 32'(bus.overflow), 32'h0);
    check("rst_irq_any", 32'(bus.irq_any), 32'h0);
    tick(2);
    rst_n = 1'b1;
    tick(2);

    // Latency: pending on the 3rd edge after sampling
    bus.irq_raw[1] = 1'b1;
    tick(2);
    check("lat_edge2_pending", 32'(bus.pending), 32'h0);
    tick();
    check("lat_edge3_pending", 32'(bus.pending), 32'h2);
    check("lat_irq_any", 32'(bus.irq_any), 32'h1);

    // Grant then done
    grant_one(4'b0010);
    check("grant_active", 32'(bus.active), 32'h2);
    check("grant_pending", 32'(bus.pending), 32'h2);
    done_one(4'b0010);
    check("done_pending", 32'(bus.pending), 32'h0);
    check("done_active", 32'(bus.active), 32'h0);
    tick();
    check("held_high_no_reevent", 32'(bus.pending), 32'h0);

    // Overflow in PEND, clear, and set-vs-clear priority
    raise_to_ev(1);
    tick();
    check("ovf_pend_reach", 32'(bus.pending), 32'h2);
    raise_to_ev(1);
    tick();
    check("ovf_set", 32'(bus.overflow), 32'h2);
    bus.overflow_clr = 1'b1;
    tick();
    bus.overflow_clr = 1'b0;
    check("ovf_clr", 32'(bus.overflow), 32'h0);
    raise_to_ev(1);
    bus.overflow_clr = 1'b1;
    tick();
    bus.overflow_clr = 1'b0;
    check("ovf_set_wins", 32'(bus.overflow), 32'h2);
    grant_one(4'b0010);
    done_one(4'b0010);
    check("ch1_idle", 32'(bus.pending), 32'h0);
    bus.overflow_clr = 1'b1;
    tick();
    bus.overflow_clr = 1'b0;
    bus.irq_raw[1] = 1'b0;
    tick(3);

    // Level mode on channel 2
    bus.irq_raw[2] = 1'b1;
    tick(3);
    check("lvl_pending", 32'(bus.pending), 32'h4);
    grant_one(4'b0100);
    check("lvl_active", 32'(bus.active), 32'h4);
    done_one(4'b0100);
    check("lvl_requeue_pending", 32'(bus.pending), 32'h4);
    check("lvl_requeue_active", 32'(bus.active), 32'h0);
    check("lvl_no_overflow", 32'(bus.overflow), 32'h0);
    bus.mask[2] = 1'b1;
    tick();
    check("lvl_masked_pending", 32'(bus.pending), 32'h0);
    check("lvl_masked_irq_any", 32'(bus.irq_any), 32'h0);
    bus.mask[2] = 1'b0;
    tick();
    check("lvl_unmask_pending", 32'(bus.pending), 32'h4);
    bus.irq_raw[2] = 1'b0;
    tick(3);
    grant_one(4'b0100);
    done_one(4'b0100);
    check("lvl_idle", 32'(bus.pending), 32'h0);

    // Edge events on channel 0 while in service
    raise_to_ev(0);
    tick();
    check("rq_pending", 32'(bus.pending), 32'h1);
    grant_one(4'b0001);
    check("rq_active", 32'(bus.active), 32'h1);
    raise_to_ev(0);
    tick();
    check("rq_first_edge_ovf", 32'(bus.overflow), REQ_EN ? 32'h0 : 32'h1);
    raise_to_ev(0);
    tick();
    check("rq_second_edge_ovf", 32'(bus.overflow), 32'h1);
    done_one(4'b0001);
    check("rq_done_pending", 32'(bus.pending), REQ_EN ? 32'h1 : 32'h0);
    check("rq_done_active", 32'(bus.active), 32'h0);
    grant_one(4'b0001);
    done_one(4'b0001);
    check("rq_final_idle", 32'(bus.pending), 32'h0);
    bus.overflow_clr = 1'b1;
    tick();
    bus.overflow_clr = 1'b0;
    bus.irq_raw[0] = 1'b0;

    // Asynchronous reset mid-service
    raise_to_ev(3);
    tick();
    check("ar_pending", 32'(bus.pending), 32'h8);
    grant_one(4'b1000);
    check("ar_active", 32'(bus.active), 32'h8);
    #2;
    rst_n = 1'b0;
    bus.irq_raw = '0;
    #1;
    check("ar_pending_now", 32'(bus.pending), 32'h0);
    check("ar_active_now", 32'(bus.active), 32'h0);
    check("ar_irq_any_now", 32'(bus.irq_any), 32'h0);
    rst_n = 1'b1;
    tick();
    grant_one(4'b1000);
    check("ar_grant_ignored_act", 32'(bus.active), 32'h0);
    check("ar_grant_ignored_pend", 32'(bus.pending), 32'h0);
    raise_to_ev(3);
    tick();
    check("ar_new_event", 32'(bus.pending), 32'h8);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
